// File: rtl/glyph_fetch_ctrl_pkg.sv
// Shared constants and types for the glyph fetch controller and its key debouncers.
package glyph_fetch_ctrl_pkg;

    localparam int glyphBytes = 5;     // ROM bytes (rows) per glyph
    localparam int glyphWidth = 8;     // pixels per glyph row
    localparam int charCount  = 26;    // 'A' .. 'Z'

    localparam logic [23:0] colourBlack = 24'h000000;
    localparam logic [23:0] colourWhite = 24'hFFFFFF;

    typedef enum logic [1:0] {
        keyIdle     = 2'd0,
        keyDebounce = 2'd1,
        keyHeld     = 2'd2
    } keyState_t;

    // ROM byte address of one glyph row; the largest result is 25*5+4 = 129, so 11 bits never wrap.
    function automatic logic [10:0] glyphAddr(input logic [5:0] index, input logic [2:0] row);
        return 11'(index) * 11'(glyphBytes) + 11'(row);
    endfunction

endpackage

// File: rtl/glyph_fetch_ctrl_key_debounce.sv
// Debounces one active-low key and emits a single-cycle pulse per accepted press.
module key_debounce
    import glyph_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] debounceCycles = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic keyRaw,
    output logic pressPulse
);

    logic [1:0]  syncChain;
    logic        keyLow;
    keyState_t   state, nextState;
    logic [15:0] count, nextCount;

    assign keyLow = ~syncChain[1];

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clock) begin
        if (reset) syncChain <= 2'b11;
        else       syncChain <= {syncChain[0], keyRaw};
    end

    // State and debounce counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= keyIdle;
            count <= '0;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    // Next-state logic: count stable-low cycles, pulse once, wait for release.
    always_comb begin
        nextState  = state;
        nextCount  = count;
        pressPulse = 1'b0;
        case (state)
            keyIdle: begin
                nextCount = '0;
                if (keyLow) nextState = keyDebounce;
            end
            keyDebounce: begin
                if (!keyLow) begin
                    nextState = keyIdle;
                    nextCount = '0;
                end else if (count == debounceCycles - 16'd1) begin
                    pressPulse = 1'b1;
                    nextState  = keyHeld;
                    nextCount  = '0;
                end else begin
                    nextCount = count + 16'd1;
                end
            end
            keyHeld: begin
                if (!keyLow) nextState = keyIdle;
            end
            default: begin
                nextState = keyIdle;
                nextCount = '0;
            end
        endcase
    end

endmodule

// File: rtl/glyph_fetch_ctrl.sv
// Two-stage pixel pipeline that renders one magnified ROM glyph, with key-driven glyph selection.
module glyph_fetch_ctrl
    import glyph_fetch_ctrl_pkg::*;
#(
    parameter int          hLength        = 11,
    parameter int          vLength        = 11,
    parameter int          originX        = 64,
    parameter int          originY        = 64,
    parameter int          scaleShift     = 3,
    parameter logic [15:0] debounceCycles = 16'd50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               key0,
    input  logic               key1,
    input  logic [hLength-1:0] hCount,
    input  logic [vLength-1:0] vCount,
    input  logic               activeVideo,
    output logic [10:0]        romAddress,
    input  logic [7:0]         romData,
    output logic [23:0]        dataOutput,
    output logic               dataValid,
    output logic [5:0]         charIndex
);

    localparam int boxWidth  = glyphWidth << scaleShift;
    localparam int boxHeight = glyphBytes << scaleShift;

    logic               advancePulse, homePulse;
    logic [5:0]         pendingIndex;
    logic [hLength-1:0] hOffset;
    logic [vLength-1:0] vOffset;
    logic               pixInBox, frameStart;
    logic [2:0]         pixRow, pixCol;
    logic               inBox_p1, vld_p1;
    logic [2:0]         col_p1;

    key_debounce #(.debounceCycles(debounceCycles)) advanceKey (
        .clock(clock), .reset(reset), .keyRaw(key0), .pressPulse(advancePulse)
    );

    key_debounce #(.debounceCycles(debounceCycles)) homeKey (
        .clock(clock), .reset(reset), .keyRaw(key1), .pressPulse(homePulse)
    );

    // Offsets wrap below the origin, so the lower bound is tested on the raw counters.
    assign hOffset    = hCount - hLength'(originX);
    assign vOffset    = vCount - vLength'(originY);
    assign pixInBox   = activeVideo
                        && (hCount >= hLength'(originX)) && (hOffset < hLength'(boxWidth))
                        && (vCount >= vLength'(originY)) && (vOffset < vLength'(boxHeight));
    assign pixCol     = 3'(hOffset >> scaleShift);
    assign pixRow     = 3'(vOffset >> scaleShift);
    assign frameStart = (hCount == '0) && (vCount == '0);

    // Glyph selection: presses accumulate any time, the display copy changes only at frame start.
    always_ff @(posedge clock) begin
        if (reset) begin
            pendingIndex <= '0;
            charIndex    <= '0;
        end else begin
            if (homePulse)
                pendingIndex <= '0;
            else if (advancePulse)
                pendingIndex <= (pendingIndex == 6'(charCount - 1)) ? 6'd0 : pendingIndex + 6'd1;
            if (frameStart)
                charIndex <= pendingIndex;
        end
    end

    // ---- stage 1: box test and ROM address (address holds outside the box) ----
    always_ff @(posedge clock) begin
        if (reset) begin
            romAddress <= '0;
            inBox_p1   <= 1'b0;
            vld_p1     <= 1'b0;
            col_p1     <= '0;
        end else begin
            inBox_p1 <= pixInBox;
            vld_p1   <= activeVideo;
            col_p1   <= pixCol;
            if (pixInBox) romAddress <= glyphAddr(charIndex, pixRow);
        end
    end

    // ---- stage 2: pixel colour from the ROM bit (bit 7 is the leftmost pixel) ----
    always_ff @(posedge clock) begin
        if (reset) begin
            dataOutput <= colourBlack;
            dataValid  <= 1'b0;
        end else begin
            dataValid <= vld_p1;
            if (!vld_p1)
                dataOutput <= colourBlack;
            else if (inBox_p1 && romData[3'd7 - col_p1])
                dataOutput <= colourBlack;
            else
                dataOutput <= colourWhite;
        end
    end

endmodule

// File: tb/tb_glyph_fetch_ctrl.sv
// Randomised self-checking bench for glyph_fetch_ctrl against a behavioural pixel/key model.
module tb_glyph_fetch_ctrl;

    localparam int OX    = 64;
    localparam int OY    = 64;
    localparam int SS    = 3;
    localparam int SCALE = 1 << SS;
    localparam int BOXW  = 8 * SCALE;
    localparam int BOXH  = 5 * SCALE;
    localparam int DEB   = 4;

    logic        clock = 1'b0;
    logic        reset, key0, key1, activeVideo;
    logic [10:0] hCount, vCount, romAddress;
    logic [7:0]  romData;
    logic [23:0] dataOutput;
    logic        dataValid;
    logic [5:0]  charIndex;

    logic [7:0]  romMem [0:2047];

    int          errCount   = 0;
    int          checkCount = 0;
    int          modelPending, modelChar, modelAddr;
    bit          prevKnown;
    logic        prevVld;
    logic [23:0] prevData;

    glyph_fetch_ctrl #(
        .hLength(11), .vLength(11), .originX(OX), .originY(OY),
        .scaleShift(SS), .debounceCycles(16'(DEB))
    ) dut (
        .clock(clock), .reset(reset), .key0(key0), .key1(key1),
        .hCount(hCount), .vCount(vCount), .activeVideo(activeVideo),
        .romAddress(romAddress), .romData(romData),
        .dataOutput(dataOutput), .dataValid(dataValid), .charIndex(charIndex)
    );

    // Asynchronous-read ROM model.
    assign romData = romMem[romAddress];

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            if (errCount <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [23:0] refPixel(input int h, input int v, input bit act, input int ch);
        logic [7:0] rowByte;
        int row, col;
        if (!act) return 24'h000000;
        if (h < OX || h >= OX + BOXW || v < OY || v >= OY + BOXH) return 24'hFFFFFF;
        row     = (v - OY) / SCALE;
        col     = (h - OX) / SCALE;
        rowByte = romMem[ch * 5 + row];
        return rowByte[7 - col] ? 24'h000000 : 24'hFFFFFF;
    endfunction

    // Apply one pixel for one clock and check the outputs of the previous pixel.
    task automatic stepPixel(input int h, input int v, input bit act);
        logic [23:0] curData;
        hCount      = 11'(h);
        vCount      = 11'(v);
        activeVideo = act;
        curData     = refPixel(h, v, act, modelChar);
        if (act && h >= OX && h < OX + BOXW && v >= OY && v < OY + BOXH)
            modelAddr = modelChar * 5 + (v - OY) / SCALE;
        if (h == 0 && v == 0) modelChar = modelPending;
        @(posedge clock);
        #1;
        checkVal("romAddress", romAddress, 32'(modelAddr));
        if (prevKnown) begin
            checkVal("dataValid", 32'(dataValid), 32'(prevVld));
            checkVal("dataOutput", 32'(dataOutput), 32'(prevData));
        end
        checkVal("charIndex", 32'(charIndex), 32'(modelChar));
        prevKnown = 1'b1;
        prevVld   = act;
        prevData  = curData;
    endtask

    // Hold the selected keys low for lowCycles, release, and let the FSMs settle.
    task automatic pressKeys(input bit use0, input bit use1, input int lowCycles);
        key0 = ~use0;
        key1 = ~use1;
        repeat (lowCycles) stepPixel(7, 3, 0);
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (6) stepPixel(7, 3, 0);
        // A press is accepted after one idle cycle plus debounceCycles stable-low cycles.
        if (lowCycles >= DEB + 1) begin
            if (use1)      modelPending = 0;
            else if (use0) modelPending = (modelPending + 1) % 26;
        end
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        checkVal("rstRomAddress", romAddress, 32'd0);
        checkVal("rstDataOutput", 32'(dataOutput), 32'd0);
        checkVal("rstDataValid", 32'(dataValid), 32'd0);
        checkVal("rstCharIndex", 32'(charIndex), 32'd0);
        reset        = 1'b0;
        modelPending = 0;
        modelChar    = 0;
        modelAddr    = 0;
        prevKnown    = 1'b1;
        prevVld      = 1'b0;
        prevData     = 24'h000000;
    endtask

    initial begin
        int lenTable [5] = '{1, 2, 3, 8, 12};
        int sweepRows [6] = '{60, 64, 71, 72, 100, 104};

        reset = 1'b1; key0 = 1'b1; key1 = 1'b1;
        hCount = '0; vCount = '0; activeVideo = 1'b0;
        prevKnown = 1'b0;
        for (int i = 0; i < 2048; i++) romMem[i] = 8'hA5;

        // Reset state and A5 sweep with glyph 0.
        doReset(3);
        stepPixel(0, 0, 0);
        foreach (sweepRows[r])
            for (int h = 0; h < 200; h++) stepPixel(h, sweepRows[r], 1);
        stepPixel(7, 3, 0);

        // Row-1 address of glyph 0.
        stepPixel(OX, OY + 8, 1);
        checkVal("addrRow1", romAddress, 32'd1);

        // Short press ignored, long press counted once.
        pressKeys(1, 0, 3);
        pressKeys(1, 0, 10);
        stepPixel(0, 0, 0);
        checkVal("singlePress", 32'(charIndex), 32'd1);

        // Glyph 3, row 1 -> 16.
        pressKeys(1, 0, 10);
        pressKeys(1, 0, 12);
        stepPixel(7, 3, 0);
        checkVal("noMidFrameChange", 32'(charIndex), 32'd1);
        stepPixel(0, 0, 0);
        stepPixel(OX + 9, OY + 8, 1);
        checkVal("addrChar3", romAddress, 32'd16);
        stepPixel(7, 3, 0);

        // 25 presses then one more wraps to 0, visible only at frame start.
        doReset(2);
        for (int i = 0; i < 25; i++) pressKeys(1, 0, $urandom_range(14, 10));
        checkVal("heldBeforeFrame", 32'(charIndex), 32'd0);
        stepPixel(0, 0, 0);
        checkVal("wrap25", 32'(charIndex), 32'd25);
        pressKeys(1, 0, 10);
        checkVal("stillAt25", 32'(charIndex), 32'd25);
        stepPixel(0, 0, 0);
        checkVal("wrap0", 32'(charIndex), 32'd0);

        // Simultaneous presses at index 7: home key wins.
        for (int i = 0; i < 7; i++) pressKeys(1, 0, 10);
        stepPixel(0, 0, 0);
        checkVal("reach7", 32'(charIndex), 32'd7);
        pressKeys(1, 1, 10);
        stepPixel(0, 0, 0);
        checkVal("bothKeys", 32'(charIndex), 32'd0);

        // Reset in the middle of a debounce discards the press.
        pressKeys(1, 0, 10);
        pressKeys(1, 0, 10);
        key0 = 1'b0;
        repeat (4) stepPixel(7, 3, 0);
        key0 = 1'b1;
        doReset(2);
        repeat (10) stepPixel(7, 3, 0);
        stepPixel(0, 0, 0);
        checkVal("rstDiscard", 32'(charIndex), 32'd0);

        // Randomised frames with random ROM contents and key activity.
        for (int it = 0; it < 6; it++) begin
            stepPixel(7, 3, 0);
            for (int i = 0; i < 2048; i++) romMem[i] = 8'($urandom);
            for (int p = $urandom_range(4, 0); p > 0; p--)
                pressKeys(1, ($urandom_range(7, 0) == 0), lenTable[$urandom_range(4, 0)]);
            stepPixel(0, 0, 0);
            for (int i = 0; i < 400; i++)
                stepPixel($urandom_range(140, 40), $urandom_range(120, 50), ($urandom_range(9, 0) != 0));
            stepPixel(7, 3, 0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
